// File: rtl/ej32_pkg.sv
// Shared eJ32 types and constants: memory arbiter state encoding and requester ids.
package ej32_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_t;

  localparam int MEM_N    = 4;
  localparam int RQ_ROM   = 0;
  localparam int RQ_LS    = 1;
  localparam int RQ_FETCH = 2;
  localparam int RQ_CON   = 3;

  // Round-robin successor over requesters 1..n-1 (index 0 never takes part)
  function automatic int rr_succ(input int idx, input int n);
    return (idx >= n - 1) ? 1 : idx + 1;
  endfunction

endpackage

// File: rtl/ej32_rr_pick.sv
// Rotating-priority picker over requesters 1..N-1, starting the search at rr_ptr.
module ej32_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      // Offset keeps the modulo operand non-negative even for rr_ptr == 0
      int cand;
      cand = 1 + ((int'(rr_ptr) + N - 2 + k) % (N - 1));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
    if (valid) onehot = N'(1) << idx;
  end

endmodule

// File: rtl/ej32_mem_arb.sv
// Arbiter/sequencer for the shared 8-bit SRAM port: fixed ROM priority, round-robin
// among the others, locked bursts with a watchdog, read data one cycle after grant.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int N       = MEM_N,
  parameter int ASZ     = 17,
  parameter int MAXLOCK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N-1:0]   we,
  input  logic [N*ASZ-1:0] addr,
  input  logic [N*8-1:0] wd,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rv,
  output logic [7:0]     rd,
  output logic           lock_err,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_wd,
  input  logic [7:0]     mem_rd
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAXLOCK + 1);

  arb_state_t     state_reg;
  logic [IW-1:0]  owner_reg;
  logic [CW-1:0]  lock_cnt_reg;
  logic [IW-1:0]  rr_ptr_reg;
  logic [N-1:0]   rv_reg;
  logic           lock_err_reg;
  logic [ASZ-1:0] a_hold_reg;
  logic [7:0]     wd_hold_reg;

  logic [ASZ-1:0] addr_arr [N];
  logic [7:0]     wd_arr   [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi] = addr[gi*ASZ +: ASZ];
      assign wd_arr[gi]   = wd[gi*8 +: 8];
    end
  endgenerate

  logic [N-1:0]  rr_onehot;
  logic [IW-1:0] rr_idx;
  logic          rr_valid;

  ej32_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .valid  (rr_valid)
  );

  logic          win_valid;
  logic [IW-1:0] win_idx;

  // Grant is masked during reset so nothing reaches the SRAM in the reset cycle
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    gnt       = '0;
    if (!rst) begin
      if (state_reg == ARB_IDLE) begin
        if (req[RQ_ROM]) begin
          win_valid = 1'b1;
          win_idx   = IW'(RQ_ROM);
          gnt       = N'(1);
        end else if (rr_valid) begin
          win_valid = 1'b1;
          win_idx   = rr_idx;
          gnt       = rr_onehot;
        end
      end else if (req[owner_reg]) begin
        win_valid = 1'b1;
        win_idx   = owner_reg;
        gnt       = N'(1) << owner_reg;
      end
    end
    mem_a  = win_valid ? addr_arr[win_idx] : a_hold_reg;
    mem_wd = win_valid ? wd_arr[win_idx]   : wd_hold_reg;
    mem_we = win_valid & we[win_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      owner_reg    <= '0;
      lock_cnt_reg <= '0;
      rr_ptr_reg   <= IW'(1);
      rv_reg       <= '0;
      lock_err_reg <= 1'b0;
      a_hold_reg   <= '0;
      wd_hold_reg  <= '0;
    end else begin
      rv_reg      <= gnt & ~we;
      a_hold_reg  <= mem_a;
      wd_hold_reg <= mem_wd;
      case (state_reg)
        ARB_IDLE: begin
          if (win_valid) begin
            if (lock[win_idx]) begin
              state_reg    <= ARB_LOCK;
              owner_reg    <= win_idx;
              lock_cnt_reg <= CW'(1);
            end
            if (win_idx != IW'(RQ_ROM))
              rr_ptr_reg <= IW'(rr_succ(int'(win_idx), N));
          end
        end
        ARB_LOCK: begin
          // A clean release wins over the watchdog in the same cycle
          if (win_valid && !lock[owner_reg]) begin
            state_reg <= ARB_IDLE;
          end else if (lock_cnt_reg == CW'(MAXLOCK)) begin
            state_reg    <= ARB_IDLE;
            lock_err_reg <= 1'b1;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign rv       = rv_reg;
  assign rd       = mem_rd;
  assign lock_err = lock_err_reg;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb: directed scenarios plus random traffic
// compared every cycle against a behavioural arbiter model and a shadow memory.
module tb_ej32_mem_arb;

  localparam int N       = 4;
  localparam int ASZ     = 17;
  localparam int MAXLOCK = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, lock, we;
  logic [ASZ-1:0] a_arr  [N];
  logic [7:0]     wd_arr [N];
  logic [N*ASZ-1:0] addr_bus;
  logic [N*8-1:0] wd_bus;
  logic [N-1:0]   gnt, rv;
  logic [7:0]     rd, mem_wd, mem_rd;
  logic           lock_err, mem_we;
  logic [ASZ-1:0] mem_a;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_bus[i*ASZ +: ASZ] = a_arr[i];
      wd_bus[i*8 +: 8]       = wd_arr[i];
    end
  end

  ej32_mem_arb #(.N(N), .ASZ(ASZ), .MAXLOCK(MAXLOCK)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr(addr_bus), .wd(wd_bus), .gnt(gnt), .rv(rv), .rd(rd),
    .lock_err(lock_err), .mem_a(mem_a), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // SRAM: synchronous write, registered read
  logic [7:0] sram [1 << ASZ];
  always @(posedge clk) begin
    if (mem_we) sram[mem_a] <= mem_wd;
    mem_rd <= sram[mem_a];
  end

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a ^ (a >> 8) ^ 8'h3C);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  bit         m_lock;
  int         m_owner, m_cnt, m_rr, m_rv;
  bit         m_err;
  int         m_hold_a, m_hold_wd, m_rd;
  logic [7:0] shadow [int];

  function automatic int mem_val(input int a);
    return shadow.exists(a) ? int'(shadow[a]) : int'(init_byte(a));
  endfunction

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_cnt = 0; m_rr = 1; m_rv = 0;
    m_err = 0; m_hold_a = 0; m_hold_wd = 0;
  endtask

  // One clock: check DUT against the model, advance the model, move to next negedge
  task automatic cycle();
    int win, c, ea, ewd, eg, ewe;
    #1;
    win = -1;
    if (!rst) begin
      if (!m_lock) begin
        if (req[0]) win = 0;
        else for (int k = 0; k < N - 1; k++) begin
          c = 1 + ((m_rr - 1 + k) % (N - 1));
          if (win < 0 && req[c]) win = c;
        end
      end else if (req[m_owner]) win = m_owner;
    end
    eg  = (win >= 0) ? (1 << win) : 0;
    ea  = (win >= 0) ? int'(a_arr[win]) : m_hold_a;
    ewd = (win >= 0) ? int'(wd_arr[win]) : m_hold_wd;
    ewe = (win >= 0) ? int'(we[win]) : 0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_a", 32'(mem_a), 32'(ea));
    chk("mem_wd", 32'(mem_wd), 32'(ewd));
    chk("rv", 32'(rv), 32'(m_rv));
    if (m_rv != 0) chk("rd", 32'(rd), 32'(m_rd));
    chk("lock_err", 32'(lock_err), 32'(m_err));
    if (rst) model_reset();
    else begin
      m_hold_a = ea; m_hold_wd = ewd;
      m_rv = (win >= 0 && !we[win]) ? (1 << win) : 0;
      if (win >= 0) begin
        if (we[win]) shadow[ea] = 8'(ewd);
        else m_rd = mem_val(ea);
      end
      if (!m_lock) begin
        if (win >= 0) begin
          if (lock[win]) begin m_lock = 1; m_owner = win; m_cnt = 1; end
          if (win != 0) m_rr = (win == N - 1) ? 1 : win + 1;
        end
      end else if (win >= 0 && !lock[win]) m_lock = 0;
      else if (m_cnt >= MAXLOCK) begin m_lock = 0; m_err = 1; end
      else m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic [3:0] w);
    rst = r; req = rq; lock = lk; we = w;
  endtask

  logic [3:0] rr_exp [6];

  initial begin
    for (int i = 0; i < (1 << ASZ); i++) sram[i] = init_byte(i);
    for (int i = 0; i < N; i++) begin a_arr[i] = ASZ'(16 * i); wd_arr[i] = 8'(i); end
    model_reset();
    drive(1, 4'hF, 4'h0, 4'h0);
    @(posedge clk); @(negedge clk);

    // 1 reset with all requests pending
    repeat (2) cycle();

    // 2 round-robin among 1..3
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0010; rr_exp[4] = 4'b0100; rr_exp[5] = 4'b1000;
    drive(0, 4'b1110, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_seq", 32'(gnt), 32'(rr_exp[i]));
      cycle();
    end

    // 3 read latency: write 0x5A at 0x1000, read it back
    a_arr[1] = 17'h1000; wd_arr[1] = 8'h5A;
    drive(0, 4'b0010, 4'h0, 4'b0010); cycle();
    drive(0, 4'b0010, 4'h0, 4'b0000);
    #1 chk("rd_gnt", 32'(gnt), 32'h2);
    cycle();
    drive(0, 4'b0000, 4'h0, 4'h0);
    #1 chk("rd_rv", 32'(rv), 32'h2);
    chk("rd_data", 32'(rd), 32'h5A);
    cycle();

    // 4 locked burst with fetch waiting (console access first realigns rr_ptr to LS)
    drive(0, 4'b1000, 4'h0, 4'h0); cycle();
    for (int i = 0; i < 5; i++) begin
      a_arr[1] = ASZ'(17'h200 + i);
      drive(0, 4'b0110, (i < 3) ? 4'b0010 : 4'b0000, 4'h0);
      #1 chk("burst_gnt", 32'(gnt), (i < 4) ? 32'h2 : 32'h4);
      if (i < 4) chk("burst_a", 32'(mem_a), 32'(17'h200 + i));
      cycle();
    end

    // 5 lock watchdog: LS takes the lock then stops requesting
    drive(0, 4'b1000, 4'h0, 4'h0); cycle();
    drive(0, 4'b0110, 4'b0010, 4'h0); cycle();
    for (int j = 1; j <= 20; j++) begin
      drive(0, 4'b0100, 4'b0010, 4'h0);
      #1;
      if (j <= MAXLOCK) chk("wd_stall", 32'(gnt), 32'h0);
      if (j == MAXLOCK + 1) begin
        chk("wd_fetch", 32'(gnt), 32'h4);
        chk("wd_err", 32'(lock_err), 32'h1);
      end
      cycle();
    end
    chk("wd_sticky", 32'(lock_err), 32'h1);

    // 6 ROM priority, then reset in the middle of an LS burst
    drive(0, 4'b0111, 4'h0, 4'h0);
    #1 chk("rom_prio", 32'(gnt), 32'h1);
    cycle();
    drive(0, 4'b0010, 4'b0010, 4'h0); cycle(); cycle();
    drive(1, 4'b0010, 4'b0010, 4'h0);
    #1 chk("rst_gnt", 32'(gnt), 32'h0);
    cycle();
    drive(0, 4'b0001, 4'h0, 4'h0);
    #1 chk("rst_idle", 32'(gnt), 32'h1);
    chk("rst_rv", 32'(rv), 32'h0);
    cycle();

    // Random traffic
    for (int t = 0; t < 800; t++) begin
      rst = ($urandom_range(0, 149) == 0);
      req[0] = ($urandom_range(0, 5) == 0);
      req[N-1:1] = 3'($urandom);
      for (int i = 0; i < N; i++) begin
        lock[i]   = ($urandom_range(0, 4) == 0);
        we[i]     = 1'($urandom);
        a_arr[i]  = ASZ'(17'h100 + $urandom_range(0, 15));
        wd_arr[i] = 8'($urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
